// File: rtl/serial_adder.sv
// serial_adder: bit-serial adder computing {cout, sum} = a + b + cin, one bit per clock, LSB first.
//
// A single full-adder cell is time-shared across all bit positions. An accepted start captures the
// operands and carry-in. WIDTH cycles of shifting then stream the operands through the cell while
// the result is reassembled in a shift register. The completed result is published on the edge
// that enters DONE. Latency is WIDTH+1 cycles of busy; throughput is one addition per WIDTH+2
// cycles.
//
// Ports
//   clk    - clock, all state updates on the rising edge
//   rst_n  - synchronous active-low reset, clears every register
//   start  - request an addition, sampled only in IDLE
//   a, b   - operands [WIDTH-1:0], captured on an accepted start
//   cin    - carry-in, captured on an accepted start
//   busy   - high in SHIFT and DONE
//   done   - one-cycle completion pulse (DONE state)
//   sum    - registered result [WIDTH-1:0], held until the next completion
//   cout   - registered carry-out, held until the next completion
//
// WIDTH is legal in 2..32.
module serial_adder #(
  parameter int unsigned WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cin,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] sum,
  output logic             cout
);

  // Counter only has to reach WIDTH-1.
  localparam int unsigned CntW = (WIDTH > 2) ? $clog2(WIDTH) : 1;
  localparam logic [CntW-1:0] CntLast = CntW'(WIDTH - 1);

  typedef enum logic [1:0] {
    StIdle,
    StShift,
    StDone
  } state_e;

  state_e            state_q, state_d;
  logic [WIDTH-1:0]  a_sr_q, a_sr_d;
  logic [WIDTH-1:0]  b_sr_q, b_sr_d;
  logic [WIDTH-1:0]  res_sr_q, res_sr_d;
  logic              carry_q, carry_d;
  logic [CntW-1:0]   cnt_q, cnt_d;
  logic [WIDTH-1:0]  sum_q, sum_d;
  logic              cout_q, cout_d;

  // The one shared full-adder cell, always looking at the operand LSBs.
  logic bit_sum;
  logic bit_carry;
  logic bit_prop;

  always_comb begin
    bit_prop  = a_sr_q[0] ^ b_sr_q[0];
    bit_sum   = bit_prop ^ carry_q;
    bit_carry = (a_sr_q[0] & b_sr_q[0]) | (carry_q & bit_prop);
  end

  always_comb begin
    state_d  = state_q;
    a_sr_d   = a_sr_q;
    b_sr_d   = b_sr_q;
    res_sr_d = res_sr_q;
    carry_d  = carry_q;
    cnt_d    = cnt_q;
    sum_d    = sum_q;
    cout_d   = cout_q;

    unique case (state_q)
      StIdle: begin
        if (start) begin
          a_sr_d   = a;
          b_sr_d   = b;
          res_sr_d = '0;
          carry_d  = cin;
          cnt_d    = '0;
          state_d  = StShift;
        end
      end

      StShift: begin
        a_sr_d   = {1'b0, a_sr_q[WIDTH-1:1]};
        b_sr_d   = {1'b0, b_sr_q[WIDTH-1:1]};
        // Result enters at the MSB so that after WIDTH shifts bit 0 sits at index 0.
        res_sr_d = {bit_sum, res_sr_q[WIDTH-1:1]};
        carry_d  = bit_carry;
        cnt_d    = cnt_q + CntW'(1);
        if (cnt_q == CntLast) begin
          // Publish only the completed word so sum/cout never expose partial results.
          sum_d   = {bit_sum, res_sr_q[WIDTH-1:1]};
          cout_d  = bit_carry;
          state_d = StDone;
        end
      end

      StDone: begin
        state_d = StIdle;
      end

      default: begin
        state_d = StIdle;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q  <= StIdle;
      a_sr_q   <= '0;
      b_sr_q   <= '0;
      res_sr_q <= '0;
      carry_q  <= 1'b0;
      cnt_q    <= '0;
      sum_q    <= '0;
      cout_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      a_sr_q   <= a_sr_d;
      b_sr_q   <= b_sr_d;
      res_sr_q <= res_sr_d;
      carry_q  <= carry_d;
      cnt_q    <= cnt_d;
      sum_q    <= sum_d;
      cout_q   <= cout_d;
    end
  end

  // Status is a pure decode of the state register.
  assign busy = (state_q != StIdle);
  assign done = (state_q == StDone);
  assign sum  = sum_q;
  assign cout = cout_q;

endmodule

// File: tb/tb_serial_adder.sv
module tb_serial_adder;

  logic clk = 1'b0;
  logic rst_n = 1'b0;

  logic       start8 = 1'b0;
  logic [7:0] a8 = '0;
  logic [7:0] b8 = '0;
  logic       cin8 = 1'b0;
  logic       busy8;
  logic       done8;
  logic [7:0] sum8;
  logic       cout8;

  logic       start4 = 1'b0;
  logic [3:0] a4 = '0;
  logic [3:0] b4 = '0;
  logic       cin4 = 1'b0;
  logic       busy4;
  logic       done4;
  logic [3:0] sum4;
  logic       cout4;

  int checks = 0;
  int failures = 0;

  logic [8:0] exp8_q[$];
  logic [4:0] exp4_q[$];

  always #5 clk = ~clk;

  serial_adder #(.WIDTH(8)) u_dut8 (
    .clk   (clk),
    .rst_n (rst_n),
    .start (start8),
    .a     (a8),
    .b     (b8),
    .cin   (cin8),
    .busy  (busy8),
    .done  (done8),
    .sum   (sum8),
    .cout  (cout8)
  );

  serial_adder #(.WIDTH(4)) u_dut4 (
    .clk   (clk),
    .rst_n (rst_n),
    .start (start4),
    .a     (a4),
    .b     (b4),
    .cin   (cin4),
    .busy  (busy4),
    .done  (done4),
    .sum   (sum4),
    .cout  (cout4)
  );

  task automatic test_reset();
    rst_n = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    checks++;
    if (busy8 !== 1'b0) begin failures++; $display("FAIL reset_busy got=%b exp=0", busy8); end
    checks++;
    if (done8 !== 1'b0) begin failures++; $display("FAIL reset_done got=%b exp=0", done8); end
    checks++;
    if (sum8 !== 8'h00) begin failures++; $display("FAIL reset_sum got=%h exp=00", sum8); end
    checks++;
    if (cout8 !== 1'b0) begin failures++; $display("FAIL reset_cout got=%b exp=0", cout8); end
    checks++;
    if ({busy4, done4, cout4, sum4} !== 7'd0) begin
      failures++;
      $display("FAIL reset_w4 got=%b exp=0", {busy4, done4, cout4, sum4});
    end
    rst_n = 1'b1;
  endtask

  // One WIDTH=8 addition observed over a fixed window. held is the result that must stay visible
  // until done; mid_start pulses a foreign start while the operation is in flight.
  task automatic run8(input logic [7:0] a, input logic [7:0] b, input logic c,
                      input logic [8:0] held, input bit mid_start, input string name);
    logic [8:0] exp;
    logic [8:0] got_exp;
    int done_k;
    int dones;
    int busy_n;
    exp = {1'b0, a} + {1'b0, b} + 9'(c);
    @(negedge clk);
    a8 = a; b8 = b; cin8 = c; start8 = 1'b1;
    exp8_q.push_back(exp);
    done_k = 0; dones = 0; busy_n = 0;
    for (int k = 1; k <= 12; k++) begin
      @(negedge clk);
      start8 = 1'b0;
      if (k == 1) begin
        // Operands are already captured; scrambling them must not matter.
        a8 = ~a; b8 = ~b; cin8 = ~c;
      end
      if (mid_start && k == 3) begin
        a8 = 8'h11; b8 = 8'h22; start8 = 1'b1;
      end
      if (busy8) busy_n++;
      if (done8) begin
        dones++;
        if (done_k == 0) done_k = k;
        checks++;
        if (exp8_q.size() == 0) begin
          failures++;
          $display("FAIL %s_extra_done got=%h exp=none", name, {cout8, sum8});
        end else begin
          got_exp = exp8_q.pop_front();
          if ({cout8, sum8} !== got_exp) begin
            failures++;
            $display("FAIL %s_result got=%h exp=%h", name, {cout8, sum8}, got_exp);
          end
        end
      end else if (dones == 0) begin
        checks++;
        if ({cout8, sum8} !== held) begin
          failures++;
          $display("FAIL %s_hold k=%0d got=%h exp=%h", name, k, {cout8, sum8}, held);
        end
      end
    end
    checks++;
    if (done_k != 9) begin failures++; $display("FAIL %s_latency got=%0d exp=9", name, done_k); end
    checks++;
    if (dones != 1) begin failures++; $display("FAIL %s_done_count got=%0d exp=1", name, dones); end
    checks++;
    if (busy_n != 9) begin failures++; $display("FAIL %s_busy_cycles got=%0d exp=9", name, busy_n); end
    checks++;
    if (busy8 !== 1'b0) begin failures++; $display("FAIL %s_idle_after got=%b exp=0", name, busy8); end
  endtask

  task automatic test_carry_ripple();
    run8(8'hFF, 8'h01, 1'b0, 9'h000, 1'b0, "ripple");
  endtask

  task automatic test_carry_in();
    run8(8'hA5, 8'h5A, 1'b1, 9'h100, 1'b0, "cin_a");
    run8(8'h7F, 8'h01, 1'b0, 9'h100, 1'b0, "cin_b");
  endtask

  task automatic test_start_during_op();
    run8(8'h03, 8'h04, 1'b0, 9'h080, 1'b1, "midstart");
  endtask

  task automatic test_reset_mid_shift();
    int dones;
    @(negedge clk);
    a8 = 8'hFF; b8 = 8'hFF; cin8 = 1'b0; start8 = 1'b1;
    for (int k = 1; k <= 4; k++) begin
      @(negedge clk);
      start8 = 1'b0;
      if (k == 4) rst_n = 1'b0;
    end
    @(negedge clk);
    checks++;
    if (busy8 !== 1'b0) begin failures++; $display("FAIL rstmid_busy got=%b exp=0", busy8); end
    checks++;
    if (done8 !== 1'b0) begin failures++; $display("FAIL rstmid_done got=%b exp=0", done8); end
    checks++;
    if ({cout8, sum8} !== 9'h000) begin
      failures++;
      $display("FAIL rstmid_result got=%h exp=000", {cout8, sum8});
    end
    rst_n = 1'b1;
    dones = 0;
    for (int k = 0; k < 12; k++) begin
      @(negedge clk);
      if (done8) dones++;
    end
    checks++;
    if (dones != 0) begin failures++; $display("FAIL rstmid_no_done got=%0d exp=0", dones); end
    run8(8'h01, 8'h01, 1'b0, 9'h000, 1'b0, "rstmid_fresh");
  endtask

  task automatic test_exhaustive4();
    logic [8:0] idx;
    logic [4:0] got_exp;
    int done_k;
    for (int i = 0; i < 512; i++) begin
      idx = 9'(i);
      @(negedge clk);
      a4 = idx[8:5]; b4 = idx[4:1]; cin4 = idx[0]; start4 = 1'b1;
      exp4_q.push_back({1'b0, idx[8:5]} + {1'b0, idx[4:1]} + 5'(idx[0]));
      done_k = 0;
      for (int k = 1; k <= 8; k++) begin
        @(negedge clk);
        start4 = 1'b0;
        if (done4) begin
          done_k = k;
          break;
        end
      end
      checks++;
      if (done_k != 5) begin
        failures++;
        $display("FAIL exh_latency i=%0d got=%0d exp=5", i, done_k);
      end
      if (done_k != 0) begin
        checks++;
        got_exp = exp4_q.pop_front();
        if ({cout4, sum4} !== got_exp) begin
          failures++;
          $display("FAIL exh_result i=%0d got=%h exp=%h", i, {cout4, sum4}, got_exp);
        end
      end else begin
        void'(exp4_q.pop_front());
        // Let a stuck DUT settle back so later iterations stay meaningful.
        repeat (8) @(negedge clk);
      end
    end
  endtask

  initial begin
    test_reset();
    test_carry_ripple();
    test_carry_in();
    test_start_during_op();
    test_reset_mid_shift();
    test_exhaustive4();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/serial_adder.md
# serial_adder

Bit-serial adder that computes `{cout, sum} = a + b + cin` one bit per clock, LSB first. It uses a single full-adder cell, a carry flip-flop and operand/result shift registers. It is the sequential stage wrapped around the full-adder cell: it captures parallel operands, streams them bit by bit through the cell, and reassembles the result. It trades WIDTH+1 cycles of latency for one adder cell instead of WIDTH.

## Interface

Parameters
- `WIDTH`, default 8: operand/result width in bits. Legal range 2..32.

Ports
- `clk`, input, 1: single clock. All state updates on the rising edge.
- `rst_n`, input, 1: synchronous, active-low reset, sampled on the rising edge of `clk`.
- `start`, input, 1: request an addition. Sampled only in IDLE.
- `a`, input, WIDTH: operand A. Captured on an accepted `start`.
- `b`, input, WIDTH: operand B. Captured on an accepted `start`.
- `cin`, input, 1: carry-in. Captured on an accepted `start`.
- `busy`, output, 1: high in SHIFT and DONE.
- `done`, output, 1: one-cycle pulse, high in DONE.
- `sum`, output, WIDTH: registered result. Holds its value until the next completion.
- `cout`, output, 1: registered carry-out. Holds its value until the next completion.

## Operation

- FSM states: IDLE, SHIFT, DONE.
- **Reset:** when `rst_n` is low at a rising edge, the block enters IDLE and clears every register:
  - `busy`=0, `done`=0, `sum`=0, `cout`=0.
  - Internal carry, bit counter and shift registers are cleared.
  - Reset takes priority over every other event, including mid-SHIFT. The partial result is discarded and `sum`/`cout` are cleared.
- **IDLE:** `start`=1 → load `a` and `b` into the operand shift registers, set carry ← `cin`, counter ← 0, go to SHIFT. `start`=0 → stay.
- **SHIFT:** each cycle:
  - s = a_sr[0] ^ b_sr[0] ^ carry.
  - carry ← (a_sr[0] & b_sr[0]) | (carry & (a_sr[0] ^ b_sr[0])).
  - Result shift register shifts right with s inserted at bit WIDTH-1.
  - a_sr and b_sr shift right with zero fill.
  - counter increments.
  - After the WIDTH-th bit (counter == WIDTH-1 at the edge), go to DONE. On that same edge, `sum` ← completed result register and `cout` ← final carry.
- **DONE:** `done`=1 for exactly one cycle, then unconditionally return to IDLE.
- `start` is ignored in SHIFT and DONE: no queuing, no effect on the operation in flight.
- Inputs `a`, `b` and `cin` may change freely after capture; the result depends only on the values captured.
- Arithmetic is unsigned modulo 2^WIDTH, with overflow in `cout`. Two's-complement callers read `sum` directly.

## Timing

- `start` accepted at edge T: `busy`=1 from T through T+WIDTH+1; `done`=1 and the new `sum`/`cout` are visible in cycle T+WIDTH+1 (after edge T+WIDTH).
- Back-to-back throughput: one addition per WIDTH+2 cycles. The earliest next accepted `start` is at edge T+WIDTH+2, which is in IDLE.
- `sum` and `cout` change only on the transition into DONE or on reset. They never show partial results.
- Outputs are purely registered; no combinational paths from inputs to outputs.

## Test plan

- **Reset values:** hold `rst_n`=0 for 2 cycles → `busy`=0, `done`=0, `sum`=0x00, `cout`=0 (WIDTH=8).
- **Carry ripple:** `a`=0xFF, `b`=0x01, `cin`=0, start at edge T → `done` high only in cycle T+9, `sum`=0x00, `cout`=1, `busy` high for exactly 9 cycles.
- **Carry-in path:** `a`=0xA5, `b`=0x5A, `cin`=1 → `sum`=0x00, `cout`=1. Then `a`=0x7F, `b`=0x01, `cin`=0 → `sum`=0x80, `cout`=0. Previous `sum` must be held until the second `done`.
- **Start during operation:** pulse `start` with `a`=0x11, `b`=0x22 while busy with 0x03+0x04 → result 0x07, `cout`=0. No second `done` appears. `busy` drops after one `done`.
- **Reset mid-SHIFT:** assert `rst_n`=0 at the 4th SHIFT cycle of 0xFF+0xFF → next cycle IDLE, `sum`=0, `cout`=0, no `done`. A fresh 0x01+0x01 afterwards → `sum`=0x02.
- **Exhaustive at WIDTH=4:** all 512 (a, b, cin) combinations, issuing each `start` in the cycle after the previous `done` → every result matches a+b+cin, and each `done` arrives 5 cycles after its `start` edge.
